// File: rtl/reg_writeback_pkg.sv
// Shared types and load-extraction helper for the RV32I writeback stage.
// The load funct3 codes match the LB/LH/LW/LBU/LHU encodings used by the decoder.
package reg_writeback_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // One queued load: 37 bits of {rd, data}.
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } ld_ext_t;

  function automatic ld_ext_t load_extract(input logic [2:0]      funct3,
                                           input logic [1:0]      addr_lo,
                                           input logic [XLEN-1:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    ld_ext_t     r;
    byte_v = word[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    r.err  = 1'b0;
    case (funct3)
      F3_LB:   r.data = {{24{byte_v[7]}}, byte_v};
      F3_LH:   r.data = {{16{half_v[15]}}, half_v};
      F3_LW:   r.data = word;
      F3_LBU:  r.data = {24'h0, byte_v};
      F3_LHU:  r.data = {16'h0, half_v};
      default: begin
        r.data = '0;
        r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// 2-deep load queue; slot0 is always the head. Exposes per-entry rd/valid
// so the writeback stage can block ALU results that would overtake a load.
module wb_load_fifo
  import reg_writeback_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  wb_entry_t            push_entry,
  input  logic                 pop,
  output wb_entry_t            head,
  output logic                 full,
  output logic                 empty,
  output logic [1:0]           ent_valid,
  output logic [1:0][RD_W-1:0] ent_rd
);

  wb_entry_t  slot0_d, slot0_q;
  wb_entry_t  slot1_d, slot1_q;
  logic [1:0] count_d, count_q;
  logic       do_push, do_pop;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    // A push into a full queue is only taken if the head leaves this cycle.
    do_push = push && ((count_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_entry;
        else                 slot1_d = push_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = push_entry;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 2'd0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign head      = slot0_q;
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign ent_valid = {count_q == 2'd2, count_q != 2'd0};
  assign ent_rd    = {slot1_q.rd, slot0_q.rd};

endmodule

// File: rtl/reg_writeback.sv
// RV32I writeback: extracts load data, queues loads, and arbitrates ALU
// results and queued loads onto the single register-file write port.
module reg_writeback
  import reg_writeback_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [RD_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [RD_W-1:0] ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_word,
  output logic            write,
  output logic [RD_W-1:0] write_addr,
  output logic [XLEN-1:0] write_data,
  output logic            ld_err,
  output logic            busy
);

  logic                 fifo_full, fifo_empty;
  logic [1:0]           ent_valid;
  logic [1:0][RD_W-1:0] ent_rd;
  wb_entry_t            head, push_entry;
  ld_ext_t              ext;
  logic                 hazard, alu_acc, ld_acc, push, pop;

  logic                 write_d, write_q;
  logic [RD_W-1:0]      write_addr_d, write_addr_q;
  logic [XLEN-1:0]      write_data_d, write_data_q;
  logic                 ld_err_d, ld_err_q;

  // An ALU result may not overtake an older queued load to the same register.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (ent_valid[i] && (ent_rd[i] == alu_rd)) hazard = 1'b1;
    end
    if (alu_rd == '0) hazard = 1'b0;
  end

  assign alu_ready = !fifo_full && !hazard;
  assign ld_ready  = !fifo_full;
  assign alu_acc   = alu_valid && alu_ready;
  assign ld_acc    = ld_valid && ld_ready;
  assign ext       = load_extract(ld_funct3, ld_addr_lo, ld_word);
  assign push      = ld_acc && (ld_rd != '0);
  assign pop       = !fifo_empty && !alu_acc;

  always_comb begin
    push_entry      = '0;
    push_entry.rd   = ld_rd;
    push_entry.data = ext.data;
  end

  wb_load_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .ent_valid  (ent_valid),
    .ent_rd     (ent_rd)
  );

  // An accepted ALU result owns the port even when its rd is x0.
  always_comb begin
    write_d      = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (alu_acc) begin
      if (alu_rd != '0) begin
        write_d      = 1'b1;
        write_addr_d = alu_rd;
        write_data_d = alu_data;
      end
    end else if (pop) begin
      write_d      = 1'b1;
      write_addr_d = head.rd;
      write_data_d = head.data;
    end
    ld_err_d = ld_acc && ext.err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q      <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      ld_err_q     <= 1'b0;
    end else begin
      write_q      <= write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      ld_err_q     <= ld_err_d;
    end
  end

  assign write      = write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign ld_err     = ld_err_q;
  assign busy       = !fifo_empty;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: extraction vector table, hand-written ordering,
// full-queue, x0 and reset sequences, then random traffic against a queue model.
module tb_reg_writeback;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_word;
  logic        write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        ld_err;
  logic        busy;

  reg_writeback dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_word    (ld_word),
    .write      (write),
    .write_addr (write_addr),
    .write_data (write_data),
    .ld_err     (ld_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
  } ext_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] word;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  // Reference model state: pending loads in order, plus the registered port.
  ent_t        m_q[$];
  logic        m_write;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ext_t ref_extract(input logic [2:0] f3, input logic [1:0] lo,
                                       input logic [31:0] w);
    ext_t        r;
    logic [31:0] b, h;
    b     = (w >> (8 * lo)) & 32'h0000_00FF;
    h     = (w >> (16 * lo[1])) & 32'h0000_FFFF;
    r.err = 0;
    case (f3)
      3'd0:    r.data = b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd1:    r.data = h[15] ? (h | 32'hFFFF_0000) : h;
      3'd2:    r.data = w;
      3'd4:    r.data = b;
      3'd5:    r.data = h;
      default: begin r.data = 32'h0; r.err = 1; end
    endcase
    return r;
  endfunction

  function automatic bit exp_alu_ready();
    bit hz = 0;
    foreach (m_q[i]) if (alu_rd != 5'd0 && m_q[i].rd == alu_rd) hz = 1;
    return (m_q.size() < 2) && !hz;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_write = 0;
    m_addr  = 5'd0;
    m_data  = 32'h0;
    m_err   = 0;
  endtask

  task automatic model_step();
    ent_t e;
    ext_t x;
    bit   aacc, lacc;
    aacc    = alu_valid && exp_alu_ready();
    lacc    = ld_valid && (m_q.size() < 2);
    m_write = 0;
    if (aacc) begin
      if (alu_rd != 5'd0) begin
        m_write = 1; m_addr = alu_rd; m_data = alu_data;
      end
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_write = 1; m_addr = e.rd; m_data = e.data;
    end
    x     = ref_extract(ld_funct3, ld_addr_lo, ld_word);
    m_err = lacc && x.err;
    if (lacc && ld_rd != 5'd0) m_q.push_back('{rd: ld_rd, data: x.data});
  endtask

  task automatic check_model();
    chk("m_write", {31'b0, write}, {31'b0, m_write});
    if (m_write) begin
      chk("m_write_addr", {27'b0, write_addr}, {27'b0, m_addr});
      chk("m_write_data", write_data, m_data);
    end
    chk("m_ld_err", {31'b0, ld_err}, {31'b0, m_err});
    chk("m_busy", {31'b0, busy}, {31'b0, m_q.size() != 0});
    chk("m_alu_ready", {31'b0, alu_ready}, {31'b0, exp_alu_ready()});
    chk("m_ld_ready", {31'b0, ld_ready}, {31'b0, m_q.size() < 2});
  endtask

  // Inputs are set at posedge+1; outputs are checked on the falling edge.
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 3'd2; ld_addr_lo = 0; ld_word = 0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1; alu_rd = rd; alu_data = d;
  endtask

  task automatic set_ld(input logic [4:0] rd, input logic [2:0] f3,
                        input logic [1:0] lo, input logic [31:0] w);
    ld_valid = 1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo; ld_word = w;
  endtask

  vec_t vecs[10];
  int   pulses;

  initial begin
    vecs[0] = '{3'd0, 2'd3, 32'h8081_F2A3, 5'd1,  32'hFFFF_FF80, 1'b0};
    vecs[1] = '{3'd4, 2'd0, 32'h8081_F2A3, 5'd2,  32'h0000_00A3, 1'b0};
    vecs[2] = '{3'd1, 2'd2, 32'h8081_F2A3, 5'd3,  32'hFFFF_8081, 1'b0};
    vecs[3] = '{3'd5, 2'd0, 32'h8081_F2A3, 5'd4,  32'h0000_F2A3, 1'b0};
    vecs[4] = '{3'd2, 2'd1, 32'h8081_F2A3, 5'd5,  32'h8081_F2A3, 1'b0};
    vecs[5] = '{3'd1, 2'd3, 32'h8081_F2A3, 5'd6,  32'hFFFF_8081, 1'b0};
    vecs[6] = '{3'd4, 2'd2, 32'h8081_F2A3, 5'd8,  32'h0000_0081, 1'b0};
    vecs[7] = '{3'd3, 2'd0, 32'h8081_F2A3, 5'd9,  32'h0000_0000, 1'b1};
    vecs[8] = '{3'd6, 2'd1, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 1'b1};
    vecs[9] = '{3'd7, 2'd2, 32'h1234_5678, 5'd31, 32'h0000_0000, 1'b1};

    idle();
    model_reset();
    rst_n = 0;
    #3;
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_write_addr", {27'b0, write_addr}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_ld_err", {31'b0, ld_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Single ALU result
    set_alu(5'd5, 32'h1234_5678);
    cycle();
    idle();
    chk("alu_write", {31'b0, write}, 32'd1);
    chk("alu_addr", {27'b0, write_addr}, 32'd5);
    chk("alu_data", write_data, 32'h1234_5678);
    cycle();
    chk("alu_write_off", {31'b0, write}, 32'd0);

    // Load extraction table
    for (int i = 0; i < 10; i++) begin
      set_ld(vecs[i].rd, vecs[i].f3, vecs[i].lo, vecs[i].word);
      cycle();
      idle();
      chk($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd1);
      chk($sformatf("vec%0d_err", i), {31'b0, ld_err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_nowrite", i), {31'b0, write}, 32'd0);
      cycle();
      chk($sformatf("vec%0d_write", i), {31'b0, write}, 32'd1);
      chk($sformatf("vec%0d_addr", i), {27'b0, write_addr}, {27'b0, vecs[i].rd});
      chk($sformatf("vec%0d_data", i), write_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_err_off", i), {31'b0, ld_err}, 32'd0);
      cycle();
      chk($sformatf("vec%0d_idle", i), {31'b0, write}, 32'd0);
    end

    // Ordering hazard on x7
    set_ld(5'd7, 3'd2, 2'd0, 32'hAAAA_0007);
    cycle();
    idle();
    set_alu(5'd7, 32'h0000_0077);
    #1 chk("hz_alu_ready_lo", {31'b0, alu_ready}, 32'd0);
    chk("hz_no_write", {31'b0, write}, 32'd0);
    cycle();
    chk("hz_ld_write", {31'b0, write}, 32'd1);
    chk("hz_ld_addr", {27'b0, write_addr}, 32'd7);
    chk("hz_ld_data", write_data, 32'hAAAA_0007);
    #1 chk("hz_alu_ready_hi", {31'b0, alu_ready}, 32'd1);
    cycle();
    idle();
    chk("hz_alu_write", {31'b0, write}, 32'd1);
    chk("hz_alu_addr", {27'b0, write_addr}, 32'd7);
    chk("hz_alu_data", write_data, 32'h0000_0077);
    cycle();
    chk("hz_idle", {31'b0, write}, 32'd0);

    // Queue fills while the ALU keeps winning, then drains in order
    set_alu(5'd20, 32'hD000_0020);
    set_ld(5'd12, 3'd2, 2'd0, 32'hAAAA_000C);
    #1 chk("full_alu_ready0", {31'b0, alu_ready}, 32'd1);
    cycle();
    set_alu(5'd21, 32'hD000_0021);
    set_ld(5'd13, 3'd2, 2'd0, 32'hBBBB_000D);
    chk("full_w20", {27'b0, write_addr}, 32'd20);
    cycle();
    set_alu(5'd13, 32'hD000_000D);
    set_ld(5'd14, 3'd2, 2'd0, 32'hCCCC_000E);
    chk("full_w21", {27'b0, write_addr}, 32'd21);
    #1;
    chk("full_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("full_alu_ready", {31'b0, alu_ready}, 32'd0);
    chk("full_busy", {31'b0, busy}, 32'd1);
    cycle();
    ld_valid = 0;
    chk("full_popA_addr", {27'b0, write_addr}, 32'd12);
    chk("full_popA_data", write_data, 32'hAAAA_000C);
    #1 chk("full_hz_block", {31'b0, alu_ready}, 32'd0);
    cycle();
    chk("full_popB_addr", {27'b0, write_addr}, 32'd13);
    chk("full_popB_data", write_data, 32'hBBBB_000D);
    cycle();
    idle();
    chk("full_alu_addr", {27'b0, write_addr}, 32'd13);
    chk("full_alu_data", write_data, 32'hD000_000D);
    cycle();
    chk("full_idle", {31'b0, write}, 32'd0);
    chk("full_empty", {31'b0, busy}, 32'd0);

    // x0 destinations
    set_alu(5'd0, 32'hDEAD_BEEF);
    cycle();
    idle();
    chk("x0_alu_nowrite", {31'b0, write}, 32'd0);
    set_ld(5'd0, 3'd2, 2'd0, 32'h1111_1111);
    cycle();
    idle();
    chk("x0_ld_notqueued", {31'b0, busy}, 32'd0);
    cycle();
    chk("x0_ld_nowrite", {31'b0, write}, 32'd0);
    set_ld(5'd0, 3'd7, 2'd0, 32'h1111_1111);
    cycle();
    idle();
    chk("x0_ld_err", {31'b0, ld_err}, 32'd1);
    cycle();
    chk("x0_ld_err_off", {31'b0, ld_err}, 32'd0);
    chk("x0_ld_err_nowrite", {31'b0, write}, 32'd0);

    // Reset while two loads are queued
    set_alu(5'd22, 32'h0000_0022);
    set_ld(5'd15, 3'd2, 2'd0, 32'h0000_000F);
    cycle();
    set_alu(5'd23, 32'h0000_0023);
    set_ld(5'd16, 3'd2, 2'd0, 32'h0000_0010);
    cycle();
    idle();
    chk("rq_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("rq_write", {31'b0, write}, 32'd0);
    chk("rq_addr", {27'b0, write_addr}, 32'd0);
    chk("rq_data", write_data, 32'd0);
    chk("rq_busy0", {31'b0, busy}, 32'd0);
    cycle();
    rst_n = 1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (write) pulses++;
    end
    chk("rq_no_pulses", pulses, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      alu_valid  = ($urandom_range(0, 99) < 60);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      ld_valid   = ($urandom_range(0, 99) < 50);
      ld_rd      = 5'($urandom_range(0, 7));
      ld_funct3  = 3'($urandom_range(0, 7));
      ld_addr_lo = 2'($urandom_range(0, 3));
      ld_word    = $urandom;
      cycle();
    end
    idle();
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
